keystream_quantizer: RTL and testbench

KEYSTREAM_QUANTIZER -- requirements
Module: keystream_quantizer

---
 rtl/keystream_quantizer_if.sv | 31 +++
 rtl/keystream_quantizer.sv | 148 ++++++++++++++
 tb/tb_keystream_quantizer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keystream_quantizer_if.sv
// Keystream quantizer bus: vector input side plus byte output side.
//
// Handshake semantics:
//   Input side:  tvalid is a single-cycle strobe with no back-pressure hold.
//                A vector is taken only on a rising edge where tvalid and
//                in_ready are both 1. tvalid while in_ready is 0 drops the vector.
//   Output side: key_valid/key_byte show the FIFO head. A byte is consumed on
//                a rising edge where key_valid and key_ready are both 1.
//                key_byte is stable while key_valid is 1 and the byte is not consumed.
interface keystream_quantizer_if #(
  parameter int PRECISION = 32
);
  logic                 tvalid;
  logic [PRECISION-1:0] x_next0;
  logic [PRECISION-1:0] x_next1;
  logic [PRECISION-1:0] x_next2;
  logic                 in_ready;
  logic [7:0]           key_byte;
  logic                 key_valid;
  logic                 key_ready;

  modport master (
    output tvalid, x_next0, x_next1, x_next2, key_ready,
    input  in_ready, key_byte, key_valid
  );

  modport slave (
    input  tvalid, x_next0, x_next1, x_next2, key_ready,
    output in_ready, key_byte, key_valid
  );
endinterface

// File: rtl/keystream_quantizer.sv
// Keystream quantizer: captures three float32 chaotic state words, converts
// each one to a keystream byte (one per cycle), and queues the bytes in a
// show-ahead FIFO for the downstream consumer.
module keystream_quantizer #(
  parameter int PRECISION = 32,  // only 32 (IEEE-754 single) is supported
  parameter int DEPTH     = 8    // power of two, at least 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  keystream_quantizer_if.slave     bus,
  output logic                     overflow_err,
  output logic                     fp_exc,
  output logic                     dbg_state,   // 1 while converting
  output logic [$clog2(DEPTH):0]   dbg_count    // FIFO occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [PRECISION-1:0] w_q [3];
  logic [PRECISION-1:0] w_d [3];
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 in_ready_q, in_ready_d;
  logic                 ovf_q, ovf_d;
  logic                 fpx_q, fpx_d;
  logic                 push, pop;
  logic [8:0]           conv;  // {exception, byte}

  // Float32 word -> {Inf/NaN flag, byte}. The value is scaled so that
  // Q = floor(|x| * 2^16); the byte folds the 16 fractional bits together.
  function automatic logic [8:0] quantize(input logic [PRECISION-1:0] bits);
    logic [7:0]  e;
    logic [31:0] sig;
    logic [31:0] q;
    logic [8:0]  res;
    e   = bits[30:23];
    sig = {8'h00, 1'b1, bits[22:0]};
    q   = '0;
    res = '0;
    if (e == 8'd255) begin
      res = 9'h100;
    end else if (e == 8'd0 || e >= 8'd150) begin
      // denormal/zero, or an integer value whose fraction is fully shifted out
      res = '0;
    end else begin
      if (e >= 8'd134) q = sig << (e - 8'd134);
      else             q = sig >> (8'd134 - e);
      res = {1'b0, q[15:8] ^ q[7:0]};
    end
    return res;
  endfunction

  // Next-state logic: capture/convert FSM, FIFO push/pop and sticky flags.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    w_d      = w_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    fpx_d    = fpx_q;
    push     = 1'b0;
    conv     = '0;
    pop      = (count_q != '0) && bus.key_ready;

    if (bus.tvalid && !in_ready_q) ovf_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.tvalid && in_ready_q) begin
          w_d[0]  = bus.x_next0;
          w_d[1]  = bus.x_next1;
          w_d[2]  = bus.x_next2;
          idx_d   = 2'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        conv = quantize(w_q[idx_q]);
        push = 1'b1;
        if (conv[8]) fpx_d = 1'b1;
        if (idx_q == 2'd2) state_d = IDLE;
        else               idx_d   = idx_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase

    // in_ready admission guarantees room for all three bytes, so push never overflows
    if (push) begin
      mem_d[wr_ptr_q] = conv[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Registered ready: next cycle is IDLE with space for a whole vector
    in_ready_d = (state_d == IDLE) && (count_d <= CNT_W'(DEPTH - 3));
  end

  // State registers; reset aborts any conversion and empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      w_q        <= '{default: '0};
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
      fpx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      w_q        <= w_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      ovf_q      <= ovf_d;
      fpx_q      <= fpx_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.key_valid = (count_q != '0);
  assign bus.key_byte  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow_err  = ovf_q;
  assign fp_exc        = fpx_q;
  assign dbg_state     = (state_q == CONV);
  assign dbg_count     = count_q;
endmodule

// File: tb/tb_keystream_quantizer.sv
// Bench for keystream_quantizer: directed vectors plus random traffic,
// checked every cycle against a real-arithmetic reference model.
module tb_keystream_quantizer;
  localparam int DEPTH = 8;

  logic       clk;
  logic       reset_n;
  logic       overflow_err;
  logic       fp_exc;
  logic       dbg_state;
  logic [3:0] dbg_count;

  keystream_quantizer_if #(.PRECISION(32)) bus_if ();

  keystream_quantizer #(.PRECISION(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if.slave),
    .overflow_err (overflow_err),
    .fp_exc       (fp_exc),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / model state
  logic [7:0] exp_q[$];   // bytes in the FIFO, head first
  logic [8:0] pend_q[$];  // {exc, byte} captured but not yet written
  logic       m_ready;
  logic       m_ovf;
  logic       m_fpx;
  int         n_checks;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: byte = fold of floor(|x| * 2^16) mod 2^16, from the real value
  function automatic logic [8:0] ref_byte(input logic [31:0] w);
    int     e;
    real    mag;
    longint v;
    e = int'(w[30:23]);
    if (e == 255) return 9'h100;
    if (e == 0) return 9'h000;
    mag = real'({1'b1, w[22:0]}) * (2.0 ** (real'(e) - 150.0));
    if (mag >= 8388608.0) return 9'h000;
    v = longint'($floor(mag * 65536.0));
    return {1'b0, v[15:8] ^ v[7:0]};
  endfunction

  task automatic model_checks();
    check("in_ready", {31'd0, bus_if.in_ready}, {31'd0, m_ready});
    check("key_valid", {31'd0, bus_if.key_valid}, (exp_q.size() != 0) ? 1 : 0);
    check("key_byte", {24'd0, bus_if.key_byte}, (exp_q.size() != 0) ? {24'd0, exp_q[0]} : 32'd0);
    check("count", {28'd0, dbg_count}, exp_q.size());
    check("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
    check("fp_exc", {31'd0, fp_exc}, {31'd0, m_fpx});
    check("converting", {31'd0, dbg_state}, (pend_q.size() != 0) ? 1 : 0);
  endtask

  // One clock: model follows the edge, tvalid is a one-cycle strobe
  task automatic step();
    bit         pop_ok, cap, ovf;
    logic [8:0] e;
    logic [31:0] w [3];
    pop_ok = bus_if.key_ready && (exp_q.size() != 0);
    cap    = bus_if.tvalid && m_ready;
    ovf    = bus_if.tvalid && !m_ready;
    w[0] = bus_if.x_next0;
    w[1] = bus_if.x_next1;
    w[2] = bus_if.x_next2;
    @(posedge clk);
    #1;
    bus_if.tvalid = 1'b0;
    if (reset_n) begin
      if (pop_ok) void'(exp_q.pop_front());
      if (pend_q.size() != 0) begin
        e = pend_q.pop_front();
        exp_q.push_back(e[7:0]);
        if (e[8]) m_fpx = 1'b1;
      end
      if (cap) for (int i = 0; i < 3; i++) pend_q.push_back(ref_byte(w[i]));
      if (ovf) m_ovf = 1'b1;
      m_ready = (pend_q.size() == 0) && ((DEPTH - exp_q.size()) >= 3);
    end
    model_checks();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus_if.x_next0 = a;
    bus_if.x_next1 = b;
    bus_if.x_next2 = c;
    bus_if.tvalid  = 1'b1;
    step();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !bus_if.in_ready; i++) step();
    check("wait_in_ready", {31'd0, bus_if.in_ready}, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    pend_q.delete();
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_fpx   = 1'b0;
    #1;
    check("rst_key_valid", {31'd0, bus_if.key_valid}, 0);
    check("rst_key_byte", {24'd0, bus_if.key_byte}, 0);
    check("rst_count", {28'd0, dbg_count}, 0);
    check("rst_in_ready", {31'd0, bus_if.in_ready}, 0);
    check("rst_overflow", {31'd0, overflow_err}, 0);
    check("rst_fp_exc", {31'd0, fp_exc}, 0);
    check("rst_state", {31'd0, dbg_state}, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("in_ready_after_reset", {31'd0, bus_if.in_ready}, 1);
  endtask

  function automatic logic [31:0] rand_word();
    int unsigned r;
    logic [7:0]  e;
    r = $urandom_range(0, 9);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else             e = 8'($urandom_range(110, 155));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    logic [7:0] lit [6];
    lit = '{8'h80, 8'h80, 8'hC0, 8'h00, 8'h80, 8'h00};
    n_checks = 0;
    n_fail   = 0;
    bus_if.tvalid    = 1'b0;
    bus_if.x_next0   = '0;
    bus_if.x_next1   = '0;
    bus_if.x_next2   = '0;
    bus_if.key_ready = 1'b1;
    reset_n          = 1'b0;
    do_reset();

    // 0.5, 0.1, 0.75 -> 80 80 C0 on consecutive cycles
    wait_ready();
    send(32'h3f000000, 32'h3dcccccd, 32'h3f400000);
    check("v1_not_yet_valid", {31'd0, bus_if.key_valid}, 0);
    step();
    check("v1_b0", {23'd0, bus_if.key_valid, bus_if.key_byte}, 32'h180);
    step();
    check("v1_b1", {23'd0, bus_if.key_valid, bus_if.key_byte}, 32'h180);
    step();
    check("v1_b2", {23'd0, bus_if.key_valid, bus_if.key_byte}, 32'h1C0);
    step();
    check("v1_drained", {31'd0, bus_if.key_valid}, 0);

    // 1.0, -0.5, 0 -> 00 80 00
    wait_ready();
    send(32'h3f800000, 32'hbf000000, 32'h00000000);
    step();
    check("v2_b0", {23'd0, bus_if.key_valid, bus_if.key_byte}, 32'h100);
    step();
    check("v2_b1", {24'd0, bus_if.key_byte}, 32'h80);
    step();
    check("v2_b2", {24'd0, bus_if.key_byte}, 32'h00);

    // Inf, 0.2, 3.0 -> 00 00 00 and fp_exc
    wait_ready();
    check("fp_exc_clear", {31'd0, fp_exc}, 0);
    send(32'h7f800000, 32'h3e4ccccd, 32'h40400000);
    step();
    check("v3_b0", {24'd0, bus_if.key_byte}, 32'h00);
    check("v3_fp_exc", {31'd0, fp_exc}, 1);
    step();
    check("v3_b1", {24'd0, bus_if.key_byte}, 32'h00);
    step();
    check("v3_b2", {24'd0, bus_if.key_byte}, 32'h00);
    step();

    // Back-pressure: two vectors fill 6 entries, third strobe overflows
    bus_if.key_ready = 1'b0;
    wait_ready();
    send(32'h3f000000, 32'h3dcccccd, 32'h3f400000);
    wait_ready();
    send(32'h3f800000, 32'hbf000000, 32'h00000000);
    for (int i = 0; i < 4; i++) step();
    check("full_in_ready", {31'd0, bus_if.in_ready}, 0);
    check("full_count", {28'd0, dbg_count}, 6);
    check("ovf_clear", {31'd0, overflow_err}, 0);
    send(32'h3f000000, 32'h3f000000, 32'h3f000000);
    check("ovf_set", {31'd0, overflow_err}, 1);
    check("ovf_count", {28'd0, dbg_count}, 6);
    step();
    check("ovf_no_capture", {31'd0, dbg_state}, 0);

    // Drain in capture order
    bus_if.key_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("drain_byte", {23'd0, bus_if.key_valid, bus_if.key_byte}, {23'd0, 1'b1, lit[i]});
      step();
    end
    check("drain_empty", {31'd0, bus_if.key_valid}, 0);
    check("drain_count", {28'd0, dbg_count}, 0);
    check("drain_in_ready", {31'd0, bus_if.in_ready}, 1);
    check("ovf_sticky", {31'd0, overflow_err}, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus_if.key_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        send(rand_word(), rand_word(), rand_word());
      end else begin
        step();
      end
    end

    // Reset one cycle after a capture discards everything
    bus_if.key_ready = 1'b0;
    wait_ready();
    send(32'h3f000000, 32'h3dcccccd, 32'h3f400000);
    step();
    do_reset();
    bus_if.key_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_stale_bytes", {31'd0, bus_if.key_valid}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
